fifo_wptr_full: RTL and testbench
=================================

Name: fifo_wptr_full

Overview:
- Write-side pointer and status generator for the dual-clock FIFO. It is the encoder counterpart of the read-domain gray decode.
- Keeps a binary write counter and converts it to a registered gray pointer for clock-domain crossing into the read domain.
- Decodes the synchronized read gray pointer to binary and produces full, almost-full and fill-level flags, all in the write clock domain.

Parameters:
- ADDR_SIZE, 4, memory address width; FIFO depth = 2**ADDR_SIZE; pointers are ADDR_SIZE+1 bits.
- AF_MARGIN, 2, almost_full asserts when free entries <= AF_MARGIN; legal range 1..2**ADDR_SIZE-1.

Ports:
- clk  input  1  write-domain clock.
- rst_n  input  1  asynchronous active-low reset.
- winc  input  1  write request; accepted only when wfull=0.
- rq2_wptr  input  ADDR_SIZE+1  read gray pointer, already passed through a 2-flop synchronizer into clk.
- waddr  output  ADDR_SIZE  binary RAM write address (low bits of the binary counter).
- wptr  output  ADDR_SIZE+1  registered gray write pointer, sent to the read-domain synchronizer.
- wen  output  1  RAM write enable = winc & ~wfull (combinational).
- wfull  output  1  registered full flag.
- almost_full  output  1  registered almost-full flag.
- wlevel  output  ADDR_SIZE+1  registered occupancy, 0..2**ADDR_SIZE.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, rst_n). While rst_n=0, wbin, wptr, wfull, almost_full and wlevel are all 0. waddr=0. Release is synchronous to the next clk edge.
- Next-state logic:
  - wbinnext = wbin + wen, modulo 2**(ADDR_SIZE+1), so the counter wraps naturally.
  - wgraynext = (wbinnext >> 1) ^ wbinnext.
- On each rising clk: wbin <= wbinnext; wptr <= wgraynext. The gray pointer changes by exactly one bit per accepted write and never glitches, because it is a register output.
- Read decode: rbin_sync is the gray-to-binary conversion of rq2_wptr, built as an XOR prefix from the MSB down. It is combinational and internal.
- Full: wfull <= (wgraynext == {~rq2_wptr[ADDR_SIZE:ADDR_SIZE-1], rq2_wptr[ADDR_SIZE-2:0]}). The two MSBs are inverted and the rest are equal.
- Level: wlevel <= (wbinnext - rbin_sync) mod 2**(ADDR_SIZE+1).
- Almost-full: almost_full <= (wbinnext - rbin_sync) >= 2**ADDR_SIZE - AF_MARGIN.
- Latency: every flag reflects the write issued in the same cycle, one cycle later. Read progress appears with 2 synchronizer cycles plus 1 register cycle of latency. Flags are therefore pessimistic (may report fuller than true, never emptier).
- winc while wfull=1: ignored. wen=0 and the pointers hold. No overflow is ever possible.
- Simultaneous write and read-pointer advance: both are applied in the same next-state computation. Level is unchanged when one write and one read land together. Full may deassert and then reassert in consecutive cycles.
- Wrap-around: the binary counter rolls from 2**(ADDR_SIZE+1)-1 to 0. waddr wraps every 2**ADDR_SIZE writes. Full and level stay correct across the wrap thanks to the extra MSB.
- Reset mid-operation: all state clears immediately, with no clock needed. The read side must be reset concurrently. Mismatched resets are out of scope.
- Invariant: wlevel never exceeds 2**ADDR_SIZE, and wfull=1 if and only if wlevel == 2**ADDR_SIZE.

Test Plan (ADDR_SIZE=4, AF_MARGIN=2, depth 16):
- Reset: rst_n=0 asynchronously mid-cycle with wbin=5 -> wptr=0, waddr=0, wfull=0, almost_full=0, wlevel=0 with no clock edge; after release and 4 writes, wptr=00110.
- Gray sequence: rq2_wptr=0, 4 single writes -> wptr goes 00001, 00011, 00010, 00110; exactly one bit toggles per step.
- Fill to full: rq2_wptr=0, 16 writes -> almost_full=1 after the 14th write, wfull=1 and wptr=11000 after the 16th. A 17th winc gives wen=0 and pointers unchanged.
- Drain while full: from full, set rq2_wptr=00001 (read bin 1) -> next cycle wfull=0, wlevel=15, almost_full=1. One more write gives wfull=1 again.
- Wrap: rq2_wptr tracks the writes with one slot of lag for 40 writes -> waddr wraps at 16 and 32, wbin 31 -> 0 transition produces wptr 10000 -> 00000, no false wfull, wlevel stays 1.
- Simultaneous: at level 8, winc=1 in the same cycle rq2_wptr advances by one -> wlevel stays 8 and no flag changes.

Source files
------------

// File: rtl/fifo_wptr_full.sv
// rtl/fifo_wptr_full.sv - write-side binary/gray pointer with full, almost-full and level flags
module fifo_wptr_full #(
  parameter int ADDR_SIZE = 4,
  parameter int AF_MARGIN = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 winc,
  input  logic [ADDR_SIZE:0]   rq2_wptr,
  output logic [ADDR_SIZE-1:0] waddr,
  output logic [ADDR_SIZE:0]   wptr,
  output logic                 wen,
  output logic                 wfull,
  output logic                 almost_full,
  output logic [ADDR_SIZE:0]   wlevel
);

  // Occupancy at or above this value means at most AF_MARGIN free entries remain.
  localparam logic [ADDR_SIZE:0] AF_THRESH = (ADDR_SIZE+1)'((1 << ADDR_SIZE) - AF_MARGIN);

  logic [ADDR_SIZE:0] wbin;
  logic [ADDR_SIZE:0] wbinnext;
  logic [ADDR_SIZE:0] wgraynext;
  logic [ADDR_SIZE:0] rbin_sync;
  logic [ADDR_SIZE:0] level_next;
  logic               full_next;

  // A write is accepted only while not full, so the counter can never overrun the reader.
  assign wen   = winc & ~wfull;
  assign waddr = wbin[ADDR_SIZE-1:0];

  assign wbinnext   = wbin + {{ADDR_SIZE{1'b0}}, wen};
  assign wgraynext  = (wbinnext >> 1) ^ wbinnext;
  assign level_next = wbinnext - rbin_sync;

  // Full when the writer is exactly one lap ahead: top two gray bits inverted, rest equal.
  assign full_next = (wgraynext == {~rq2_wptr[ADDR_SIZE:ADDR_SIZE-1],
                                    rq2_wptr[ADDR_SIZE-2:0]});

  // Gray-to-binary of the synchronized read pointer, XOR prefix from the MSB down.
  always_comb begin
    rbin_sync = '0;
    rbin_sync[ADDR_SIZE] = rq2_wptr[ADDR_SIZE];
    for (int i = ADDR_SIZE - 1; i >= 0; i--) begin
      rbin_sync[i] = rbin_sync[i+1] ^ rq2_wptr[i];
    end
  end

  // Pointer and flag registers; the gray pointer is registered so the crossing never sees glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbin        <= '0;
      wptr        <= '0;
      wfull       <= 1'b0;
      almost_full <= 1'b0;
      wlevel      <= '0;
    end else begin
      wbin        <= wbinnext;
      wptr        <= wgraynext;
      wfull       <= full_next;
      almost_full <= (level_next >= AF_THRESH);
      wlevel      <= level_next;
    end
  end

endmodule

// File: tb/tb_fifo_wptr_full.sv
// tb/tb_fifo_wptr_full.sv - directed self-checking bench for fifo_wptr_full
module tb_fifo_wptr_full;

  logic       clk;
  logic       rst_n;
  logic       winc;
  logic [4:0] rq2_wptr;
  logic [3:0] waddr;
  logic [4:0] wptr;
  logic       wen;
  logic       wfull;
  logic       almost_full;
  logic [4:0] wlevel;

  int n_assert = 0;
  int n_fail   = 0;

  fifo_wptr_full #(.ADDR_SIZE(4), .AF_MARGIN(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .winc        (winc),
    .rq2_wptr    (rq2_wptr),
    .waddr       (waddr),
    .wptr        (wptr),
    .wen         (wen),
    .wfull       (wfull),
    .almost_full (almost_full),
    .wlevel      (wlevel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] gray5(input int b);
    logic [4:0] v;
    v = 5'(b);
    return (v >> 1) ^ v;
  endfunction

  logic [4:0] gray_tab [4];
  logic [4:0] prev;

  initial begin
    gray_tab[0] = 5'b00001;
    gray_tab[1] = 5'b00011;
    gray_tab[2] = 5'b00010;
    gray_tab[3] = 5'b00110;

    rst_n = 1'b0; winc = 1'b0; rq2_wptr = 5'b0;
    repeat (2) tick();
    check("rst_wptr",   32'(wptr),   32'h0);
    check("rst_wfull",  32'(wfull),  32'h0);
    check("rst_wlevel", 32'(wlevel), 32'h0);
    rst_n = 1'b1;
    tick();

    // Five writes, then asynchronous reset mid-cycle
    winc = 1'b1;
    repeat (5) tick();
    winc = 1'b0;
    check("pre_rst_waddr", 32'(waddr), 32'h5);
    check("pre_rst_wptr",  32'(wptr),  32'b00111);
    check("pre_rst_level", 32'(wlevel), 32'h5);
    #3 rst_n = 1'b0;
    #1;
    check("async_wptr",  32'(wptr),        32'h0);
    check("async_waddr", 32'(waddr),       32'h0);
    check("async_full",  32'(wfull),       32'h0);
    check("async_af",    32'(almost_full), 32'h0);
    check("async_level", 32'(wlevel),      32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // Gray sequence, one bit per write
    winc = 1'b1;
    prev = wptr;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("gray_seq", 32'(wptr), 32'(gray_tab[i]));
      check("gray_onebit", 32'($countones(prev ^ wptr)), 32'd1);
      prev = wptr;
    end

    // Fill to full
    for (int n = 5; n <= 16; n++) begin
      tick();
      check("fill_level", 32'(wlevel),      32'(n));
      check("fill_af",    32'(almost_full), (n >= 14) ? 32'd1 : 32'd0);
      check("fill_full",  32'(wfull),       (n == 16) ? 32'd1 : 32'd0);
    end
    check("full_wptr", 32'(wptr), 32'b11000);
    #1;
    check("full_wen", 32'(wen), 32'h0);
    tick();
    check("ovf_wptr",  32'(wptr),   32'b11000);
    check("ovf_waddr", 32'(waddr),  32'h0);
    check("ovf_level", 32'(wlevel), 32'd16);

    // Drain one while full
    winc = 1'b0;
    rq2_wptr = 5'b00001;
    tick();
    check("drain_full",  32'(wfull),       32'h0);
    check("drain_level", 32'(wlevel),      32'd15);
    check("drain_af",    32'(almost_full), 32'h1);
    winc = 1'b1;
    #1;
    check("refill_wen", 32'(wen), 32'h1);
    tick();
    winc = 1'b0;
    check("refill_full",  32'(wfull),  32'h1);
    check("refill_wptr",  32'(wptr),   32'b11001);
    check("refill_level", 32'(wlevel), 32'd16);

    // Simultaneous write and read advance at level 8
    rq2_wptr = 5'b01101;
    tick();
    check("lvl8_level", 32'(wlevel),      32'd8);
    check("lvl8_af",    32'(almost_full), 32'h0);
    winc = 1'b1;
    rq2_wptr = 5'b01111;
    tick();
    winc = 1'b0;
    check("simul_level", 32'(wlevel),      32'd8);
    check("simul_af",    32'(almost_full), 32'h0);
    check("simul_full",  32'(wfull),       32'h0);
    check("simul_waddr", 32'(waddr),       32'h2);

    // Wrap-around with the reader one slot behind
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      rq2_wptr = gray5(k);
      winc = 1'b1;
      tick();
      check("wrap_level", 32'(wlevel), 32'd1);
      check("wrap_full",  32'(wfull),  32'h0);
      check("wrap_waddr", 32'(waddr),  32'((k + 1) % 16));
      check("wrap_wptr",  32'(wptr),   32'(gray5(k + 1)));
      if (k == 30) check("wrap_wptr31", 32'(wptr), 32'b10000);
      if (k == 31) check("wrap_wptr32", 32'(wptr), 32'b00000);
    end
    winc = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
